// File: rtl/kernel_bc_fifo_pkg.sv
// Shared constants and helpers for the kernel_bc start-token FIFO family.
// Error-bit indices apply to builds with KERNEL_BC_START_FANOUT_ERR_EN defined.
package kernel_bc_fifo_pkg;

   localparam int ERR_OVF = 0;
   localparam int ERR_UDF = 1;
   localparam int ERR_W   = 2;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

   // Occupancy must reach DEPTH itself, hence one bit more than the address.
   function automatic int cnt_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/kernel_bc_start_fanout_fifo_if.sv
// Producer/consumer bundle for kernel_bc_start_fanout_fifo.
// if_err exists only when KERNEL_BC_START_FANOUT_ERR_EN is defined.
interface kernel_bc_start_fanout_fifo_if #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 2,
   parameter int NUM_CH     = 2
);
   localparam int CNT_W = kernel_bc_fifo_pkg::cnt_width(ADDR_WIDTH);

   // Handshake: a write transfers on an edge where if_write & if_write_ce & if_full_n;
   // channel c transfers on an edge where if_read[c] & if_read_ce[c] & if_empty_n[c].
   // Requests outside those conditions are dropped, never held pending.
   logic                         if_write;
   logic                         if_write_ce;
   logic [DATA_WIDTH-1:0]        if_din;
   logic                         if_full_n;
   logic [NUM_CH-1:0]            if_read;
   logic [NUM_CH-1:0]            if_read_ce;
   logic [NUM_CH-1:0]            if_empty_n;
   logic [NUM_CH*DATA_WIDTH-1:0] if_dout;
   logic [NUM_CH*CNT_W-1:0]      if_count;
`ifdef KERNEL_BC_START_FANOUT_ERR_EN
   logic [kernel_bc_fifo_pkg::ERR_W-1:0] if_err;
`endif

   modport master (
      output if_write, if_write_ce, if_din, if_read, if_read_ce,
`ifdef KERNEL_BC_START_FANOUT_ERR_EN
      input  if_err,
`endif
      input  if_full_n, if_empty_n, if_dout, if_count
   );

   modport slave (
      input  if_write, if_write_ce, if_din, if_read, if_read_ce,
`ifdef KERNEL_BC_START_FANOUT_ERR_EN
      output if_err,
`endif
      output if_full_n, if_empty_n, if_dout, if_count
   );

endinterface

// File: rtl/kernel_bc_start_fanout_fifo_shiftReg.sv
// Shared DEPTH x DATA_WIDTH token store: one shift enable, NUM_CH combinational read ports.
module kernel_bc_start_fanout_fifo_shiftReg #(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2,
   parameter int NUM_CH     = 2
) (
   input  logic                         clk,
   input  logic                         shift_en,
   input  logic [DATA_WIDTH-1:0]        din,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_CH*DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Entry 0 is always the newest token; storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (shift_en) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            mem[i] <= mem[i-1];
         end
         mem[0] <= din;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         rd_data[c*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH]];
      end
   end

endmodule

// File: rtl/kernel_bc_start_fanout_fifo.sv
// Broadcast start-token FIFO: one writer, NUM_CH independently draining readers.
// Optional sticky error flags when KERNEL_BC_START_FANOUT_ERR_EN is defined.
module kernel_bc_start_fanout_fifo
   import kernel_bc_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2,
   parameter int NUM_CH     = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   kernel_bc_start_fanout_fifo_if.slave  bus
);

   localparam int                CNT_W    = cnt_width(ADDR_WIDTH);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

   logic [CNT_W-1:0]             cnt_q [NUM_CH];
   logic [CNT_W-1:0]             cnt_d [NUM_CH];
   logic [NUM_CH-1:0]            empty_n_q;
   logic                         full_n_q;
   logic                         wr;
   logic [NUM_CH-1:0]            rd;
   logic [NUM_CH-1:0]            cnt_d_full;
   logic [NUM_CH*ADDR_WIDTH-1:0] head_addr;

   // The oldest token of channel c sits at cnt-1 because every write shifts it up.
   always_comb begin
      wr         = bus.if_write & bus.if_write_ce & full_n_q;
      rd         = bus.if_read & bus.if_read_ce & empty_n_q;
      head_addr  = '0;
      cnt_d_full = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         cnt_d[c] = cnt_q[c];
         if (wr && !rd[c]) begin
            cnt_d[c] = cnt_q[c] + 1'b1;
         end else if (!wr && rd[c]) begin
            cnt_d[c] = cnt_q[c] - 1'b1;
         end
         if (cnt_q[c] != '0) begin
            head_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(cnt_q[c] - 1'b1);
         end
         cnt_d_full[c] = (cnt_d[c] == FULL_CNT);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c] <= '0;
         end
         empty_n_q <= '0;
         full_n_q  <= 1'b1;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_q[c]     <= cnt_d[c];
            empty_n_q[c] <= (cnt_d[c] != '0);
         end
         full_n_q <= ~|cnt_d_full;
      end
   end

   kernel_bc_start_fanout_fifo_shiftReg #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_CH     (NUM_CH)
   ) u_store (
      .clk      (clk),
      .shift_en (wr & ~reset),
      .din      (bus.if_din),
      .rd_addr  (head_addr),
      .rd_data  (bus.if_dout)
   );

   assign bus.if_full_n  = full_n_q;
   assign bus.if_empty_n = empty_n_q;

   always_comb begin
      bus.if_count = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         bus.if_count[c*CNT_W +: CNT_W] = cnt_q[c];
      end
   end

`ifdef KERNEL_BC_START_FANOUT_ERR_EN
   logic [ERR_W-1:0] err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= '0;
      end else begin
         if (bus.if_write && bus.if_write_ce && !full_n_q) begin
            err_q[ERR_OVF] <= 1'b1;
         end
         if (|(bus.if_read & bus.if_read_ce & ~empty_n_q)) begin
            err_q[ERR_UDF] <= 1'b1;
         end
      end
   end

   assign bus.if_err = err_q;
`endif

endmodule

// File: tb/tb_kernel_bc_start_fanout_fifo.sv
// Directed bench for kernel_bc_start_fanout_fifo: queue-based reference model plus literal checks.
module tb_kernel_bc_start_fanout_fifo;

   localparam int DW    = 1;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int NC    = 2;
   localparam int CW    = AW + 1;

   logic clk;
   logic reset;

   kernel_bc_start_fanout_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) bus ();

   kernel_bc_start_fanout_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW),
      .NUM_CH     (NC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: every accepted token is logged once; each channel keeps a read index.
   logic [DW-1:0] exp_q[$];
   int            rd_idx [NC];
   logic [1:0]    err_m;
   bit            model_on = 0;

   function automatic int cnt_m(input int c);
      return exp_q.size() - rd_idx[c];
   endfunction

   always @(posedge clk) begin
      bit full_m;
      if (reset) begin
         exp_q.delete();
         for (int c = 0; c < NC; c++) rd_idx[c] = 0;
         err_m    = 2'b00;
         model_on = 1;
      end else if (model_on) begin
         full_m = 0;
         for (int c = 0; c < NC; c++) if (cnt_m(c) == DEPTH) full_m = 1;
         for (int c = 0; c < NC; c++) begin
            if (bus.if_read[c] && bus.if_read_ce[c]) begin
               if (cnt_m(c) > 0) rd_idx[c]++;
               else err_m[1] = 1'b1;
            end
         end
         if (bus.if_write && bus.if_write_ce) begin
            if (!full_m) exp_q.push_back(bus.if_din);
            else err_m[0] = 1'b1;
         end
      end
      #1;
      if (model_on) begin
         bit any_full;
         any_full = 0;
         for (int c = 0; c < NC; c++) begin
            check($sformatf("count[%0d]", c), 32'(bus.if_count[c*CW +: CW]), 32'(cnt_m(c)));
            check($sformatf("empty_n[%0d]", c), 32'(bus.if_empty_n[c]), 32'(cnt_m(c) != 0));
            if (cnt_m(c) > 0)
               check($sformatf("dout[%0d]", c), 32'(bus.if_dout[c*DW +: DW]), 32'(exp_q[rd_idx[c]]));
            if (cnt_m(c) == DEPTH) any_full = 1;
         end
         check("full_n", 32'(bus.if_full_n), 32'(!any_full));
`ifdef KERNEL_BC_START_FANOUT_ERR_EN
         check("err", 32'(bus.if_err), 32'(err_m));
`endif
      end
   end

   // driver tasks: drive on the falling edge, return just after the next rising edge
   task automatic step(input logic w, input logic wce, input logic [DW-1:0] d,
                       input logic [NC-1:0] r, input logic [NC-1:0] rce);
      @(negedge clk);
      bus.if_write    = w;
      bus.if_write_ce = wce;
      bus.if_din      = d;
      bus.if_read     = r;
      bus.if_read_ce  = rce;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset           = 1'b1;
      bus.if_write    = 1'b1;
      bus.if_write_ce = 1'b1;
      bus.if_din      = 1'b1;
      bus.if_read     = '1;
      bus.if_read_ce  = '1;
      @(posedge clk);
      #2;
      @(negedge clk);
      reset           = 1'b0;
      bus.if_write    = 1'b0;
      bus.if_read     = '0;
   endtask

   initial begin
      reset           = 1'b1;
      bus.if_write    = 1'b0;
      bus.if_write_ce = 1'b0;
      bus.if_din      = '0;
      bus.if_read     = '0;
      bus.if_read_ce  = '0;
      do_reset();
      check("lit reset count", 32'(bus.if_count), 32'(0));
      check("lit reset full_n", 32'(bus.if_full_n), 32'(1));

      // fill both channels with 1,0,1,1, then a dropped 5th write
      step(1, 1, 1'b1, 2'b00, 2'b11);
      step(1, 1, 1'b0, 2'b00, 2'b11);
      step(1, 1, 1'b1, 2'b00, 2'b11);
      step(1, 1, 1'b1, 2'b00, 2'b11);
      check("lit full after 4", 32'(bus.if_full_n), 32'(0));
      step(1, 1, 1'b0, 2'b00, 2'b11);
      check("lit count after drop", 32'(bus.if_count), 32'({3'd4, 3'd4}));
      check("lit head t1", 32'(bus.if_dout), 32'(2'b11));
      step(0, 1, 1'b0, 2'b11, 2'b11);
      check("lit head t2", 32'(bus.if_dout), 32'(2'b00));
      step(0, 1, 1'b0, 2'b11, 2'b11);
      check("lit head t3", 32'(bus.if_dout), 32'(2'b11));
      step(0, 1, 1'b0, 2'b11, 2'b11);
      check("lit head t4", 32'(bus.if_dout), 32'(2'b11));
      step(0, 1, 1'b0, 2'b11, 2'b11);
      check("lit drained", 32'(bus.if_empty_n), 32'(2'b00));

      // write with clock enable low is not a write
      step(1, 0, 1'b1, 2'b00, 2'b11);
      check("lit wce gate", 32'(bus.if_count), 32'(0));

      // channel 0 reads continuously, channel 1 idle, six writes offered
      step(1, 1, 1'b1, 2'b01, 2'b11);
      step(1, 1, 1'b0, 2'b01, 2'b11);
      step(1, 1, 1'b1, 2'b01, 2'b11);
      step(1, 1, 1'b0, 2'b01, 2'b11);
      step(1, 1, 1'b1, 2'b01, 2'b11);
      step(1, 1, 1'b1, 2'b01, 2'b11);
      check("lit stall count", 32'(bus.if_count), 32'({3'd4, 3'd0}));
      check("lit stall full_n", 32'(bus.if_full_n), 32'(0));

      // one read on channel 1 reopens the writer
      step(0, 1, 1'b0, 2'b10, 2'b11);
      check("lit reopen full_n", 32'(bus.if_full_n), 32'(1));
      step(1, 1, 1'b1, 2'b00, 2'b11);
      check("lit reopen count", 32'(bus.if_count), 32'({3'd4, 3'd1}));
      check("lit ch1 2nd token", 32'(bus.if_dout[1]), 32'(0));
      // read enable low on channel 1 is not a read
      step(0, 1, 1'b0, 2'b10, 2'b01);
      check("lit rce gate", 32'(bus.if_count), 32'({3'd4, 3'd1}));
      for (int i = 0; i < 4; i++) step(0, 1, 1'b0, 2'b11, 2'b11);
      check("lit drained 2", 32'(bus.if_count), 32'(0));

      // simultaneous write and read on channel 0 with cnt = 2
      step(1, 1, 1'b1, 2'b00, 2'b11);
      step(1, 1, 1'b0, 2'b00, 2'b11);
      step(1, 1, 1'b1, 2'b01, 2'b11);
      check("lit wr+rd count", 32'(bus.if_count), 32'({3'd3, 3'd2}));
      check("lit wr+rd head", 32'(bus.if_dout[0]), 32'(0));
      step(0, 1, 1'b0, 2'b01, 2'b11);
      check("lit order next", 32'(bus.if_dout[0]), 32'(1));
      step(0, 1, 1'b0, 2'b01, 2'b11);
      check("lit ch0 empty", 32'(bus.if_empty_n), 32'(2'b10));

      // reset with counts {3,1}
      step(0, 1, 1'b0, 2'b10, 2'b11);
      step(1, 1, 1'b0, 2'b00, 2'b11);
      check("lit pre-reset count", 32'(bus.if_count), 32'({3'd3, 3'd1}));
      do_reset();
      check("lit mid reset count", 32'(bus.if_count), 32'(0));
      check("lit mid reset empty_n", 32'(bus.if_empty_n), 32'(2'b00));
      check("lit mid reset full_n", 32'(bus.if_full_n), 32'(1));

      // rejected requests: underflow on channel 1, then overflow
      step(0, 1, 1'b0, 2'b10, 2'b11);
`ifdef KERNEL_BC_START_FANOUT_ERR_EN
      check("lit err udf", 32'(bus.if_err), 32'(2'b10));
`endif
      for (int i = 0; i < 4; i++) step(1, 1, 1'(i), 2'b00, 2'b11);
      step(1, 1, 1'b1, 2'b00, 2'b11);
      check("lit ovf dropped", 32'(bus.if_count), 32'({3'd4, 3'd4}));
`ifdef KERNEL_BC_START_FANOUT_ERR_EN
      check("lit err ovf", 32'(bus.if_err), 32'(2'b11));
      step(0, 1, 1'b0, 2'b11, 2'b11);
      check("lit err sticky", 32'(bus.if_err), 32'(2'b11));
      do_reset();
      check("lit err cleared", 32'(bus.if_err), 32'(2'b00));
`endif

      step(0, 0, 1'b0, 2'b00, 2'b00);
      step(0, 0, 1'b0, 2'b00, 2'b00);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/kernel_bc_start_fanout_fifo.md
# kernel_bc_start_fanout_fifo

Parametrised start-token FIFO with one producer and NUM_CH independent consumers, for dataflow regions where one task's completion must start several downstream tasks. Every accepted write is broadcast to all channels; each channel drains at its own pace. The block replaces per-consumer start FIFO copies with one shared shift-register store and per-channel occupancy tracking.

## Interface
- DATA_WIDTH, 1: token width in bits.
- DEPTH, 4: entries per channel, 2..64.
- ADDR_WIDTH, 2: ceil(log2(DEPTH)).
- NUM_CH, 2: consumer channel count, 1..8.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- if_write  in  1  producer write request.
- if_write_ce  in  1  producer clock enable; a write is effective only when if_write & if_write_ce.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  high when every channel has at least one free entry.
- if_read  in  NUM_CH  per-channel read request.
- if_read_ce  in  NUM_CH  per-channel clock enable.
- if_empty_n  out  NUM_CH  per-channel data valid.
- if_dout  out  NUM_CH*DATA_WIDTH  per-channel head token; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- if_count  out  NUM_CH*(ADDR_WIDTH+1)  per-channel occupancy, 0..DEPTH.

## Operation
- Storage is a DEPTH-entry shift register. An accepted write shifts all entries up by one and loads if_din into entry 0.
- Write accepted: wr = if_write & if_write_ce & if_full_n. A write offered while full is dropped and storage is unchanged.
- Read accepted on channel c: rd[c] = if_read[c] & if_read_ce[c] & if_empty_n[c]. A read while empty is ignored.
- Per-channel count cnt[c]:
  - wr & !rd[c]: +1.
  - rd[c] & !wr: -1.
  - both or neither: unchanged.
- Head address for channel c is cnt[c]-1 when cnt[c]>0, otherwise 0. if_dout[c] = storage[head address], read combinationally (first-word fall-through).
- if_empty_n[c] = (cnt[c] != 0). if_full_n = AND over c of (cnt[c] != DEPTH). Both are registered and updated in the same edge as the counts.
- Flow control is gated by the slowest channel. A full channel blocks the writer even if that channel reads in the same cycle, because if_full_n is registered.

## Timing
- Reset values: every cnt = 0, if_empty_n = 0, if_full_n = 1, if_count = 0, error flags = 0. Storage is not reset, so if_dout is undefined until the first write.
- A reset asserted mid-operation discards all tokens in the next cycle. Inputs are ignored while reset is high.
- Write to visibility: a token accepted at edge N gives if_empty_n[c] = 1 and valid if_dout[c] after edge N, i.e. one cycle of latency.
- A read at edge N presents the next token on if_dout[c] after edge N.
- Simultaneous write and read on a channel: the count holds and the head address is unchanged. The shift moves the next-oldest token under the pointer.
- Full deassertion: after a read edge on the last full channel, if_full_n = 1 from the next cycle.
- Channel independence: a read on channel c never changes cnt[d] for d != c.

## Configuration
- KERNEL_BC_START_FANOUT_ERR_EN defined:
  - Adds output if_err (2 bits, sticky, cleared only by reset).
  - Bit 0 is set on a write attempt (if_write & if_write_ce) while if_full_n = 0.
  - Bit 1 is set on a read attempt on any channel while that channel's if_empty_n = 0.
- Macro undefined: port if_err does not exist, and rejected requests are silently ignored as described above.

## Structure
- Shared package kernel_bc_fifo_pkg contains:
  - the clog2 helper;
  - the count-width constant rule (ADDR_WIDTH+1);
  - error-bit index constants ERR_OVF = 0 and ERR_UDF = 1.
- Sub-module kernel_bc_start_fanout_fifo_shiftReg holds the DEPTH x DATA_WIDTH shift register with one shift enable and NUM_CH combinational read ports.
- The top level holds the per-channel counters, the flags and the error logic.

## Test plan
- Reset, then DEPTH=4, NUM_CH=2, write 0x1,0x0,0x1,0x1 with no reads -> if_full_n = 0 after the 4th edge; a 5th write is dropped; both channels later read 1,0,1,1.
- Channel 0 reads continuously while channel 1 is idle; write 6 tokens -> the writer stalls after 4; channel 0 receives 4 tokens; if_count = {4,0} as {ch1,ch0}.
- Channel 1 reads once -> if_full_n = 1 one cycle later; the next write is accepted; channel 1's head equals its 2nd token.
- With cnt = 2 on channel 0, a simultaneous write and read on channel 0 -> count stays 2; if_dout[0] shows the older remaining token; order is preserved over the next 2 reads.
- Reset asserted with cnt = {3,1} -> after 1 edge all counts are 0, if_empty_n = 00, if_full_n = 1.
- ERR_EN build: read channel 1 while empty, then write while full -> if_err = 2'b10 after the first event and 2'b11 after the second; only reset clears it.
